ex_muldiv_seq: RTL
==================

# ex_muldiv_seq

Multi-cycle multiply/divide sequencer attached to the EX stage beside the single-cycle ALU. It accepts one unsigned MUL/MULHU/DIVU/REMU operation from the EX pipeline register, runs it iteratively over WIDTH cycles, and holds the pipeline with a stall signal until the result is ready. It then presents the result for one cycle so EX can write it into ALUout's slot in the EX/MEM register.

## Interface
- WIDTH, 32, operand and result width in bits
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- start  in  1  EX holds a mul/div instruction; sampled only in IDLE
- op  in  2  00 MUL (low product), 01 MULHU (high product), 10 DIVU (quotient), 11 REMU (remainder)
- opA  in  WIDTH  multiplicand or dividend (busA after forwarding)
- opB  in  WIDTH  multiplier or divisor (busB after forwarding)
- flush  in  1  kill in-flight op (branch or jump taken ahead of EX)
- stall  out  1  freeze IF/ID/EX pipeline registers
- busy  out  1  operation in progress (state CALC)
- done  out  1  one-cycle pulse: result valid
- result  out  WIDTH  selected result; holds until next accepted start

## Operation
- States: IDLE, CALC, DONE.
- IDLE:
  - start=1 and flush=0: latch op, opA, opB; clear the 6-bit counter.
  - Multiply: clear the 2·WIDTH product accumulator; go to CALC.
  - Divide with opB≠0: clear the WIDTH-bit remainder; load quotient register with opA; go to CALC.
  - Divide with opB=0: go directly to DONE. DIVU result is all ones; REMU result is opA.
- CALC, multiply: shift-add, one multiplier bit per cycle, LSB first. The product is exact 2·WIDTH unsigned. MUL selects bits [WIDTH-1:0]; MULHU selects bits [2·WIDTH-1:WIDTH].
- CALC, divide: restoring division, one quotient bit per cycle, MSB first. Each cycle forms {rem, q_msb} minus divisor at WIDTH+1 bits; if non-negative, keep the difference and set the quotient bit to 1.
- CALC: counter increments each cycle. Leave for DONE after the cycle with counter = WIDTH-1 (WIDTH iterations).
- DONE: done=1; result register loaded on entry to DONE. Always return to IDLE next cycle. start is ignored in DONE.
- flush=1 in CALC: go to IDLE next edge, no done, result unchanged.
- flush=1 in IDLE: start is ignored. flush in DONE has no effect: the result is already committed.
- stall = (state==CALC) | (state==IDLE & start & ~flush). This is combinational, so the pipeline freezes in the same cycle start is seen.
- busy = (state==CALC). done = (state==DONE). Both are registered-state decodes.

## Timing
- Reset (rst_n=0, asynchronous): state=IDLE; counter, accumulators and result = 0; done=0; busy=0. stall follows its equation: 0 unless start is high in IDLE.
- Reset mid-operation aborts immediately: no done and result=0.
- Normal latency, with start accepted at edge 0:
  - CALC during cycles 1..WIDTH.
  - done=1 in cycle WIDTH+1 (cycle 33 for WIDTH=32), with stall=0 that cycle.
  - The pipeline advances at the end of the done cycle.
- Divide by zero: done in cycle 1 (next cycle after start).
- Back-to-back: the next instruction's start is seen in IDLE at cycle WIDTH+2 at the earliest.
- Operands are captured at acceptance; later changes on opA/opB do not affect the result.
- result is stable from the done cycle until the next done, except on reset.

## Test plan
- MUL 7×6: start with op=00 → done at cycle 33, result=0x0000002A; stall high in cycles 0–32, low at 33.
- MULHU 0xFFFFFFFF×0xFFFFFFFF → result=0xFFFFFFFE. MUL with the same operands → 0x00000001.
- DIVU 100/7 → 0x0000000E. REMU 100/7 → 0x00000002. DIVU 0x80000000/1 → 0x80000000. All done at cycle 33.
- DIVU 5/0 → done at cycle 1, result=0xFFFFFFFF, busy never asserts. REMU 5/0 → result=0x00000005.
- MUL started, flush at cycle 10 → IDLE at cycle 11, no done pulse, result unchanged. Start with flush=1 in IDLE → not accepted, stall=0.
- rst_n low at cycle 20 of DIVU → state IDLE and busy=0 immediately, result=0. After release, a new MUL 3×3 gives result=9 in cycle 33.

Source files
------------

// File: rtl/ex_muldiv_seq.sv
// Purpose: iterative unsigned MUL/MULHU/DIVU/REMU unit sitting beside the EX-stage ALU.
// Latency: WIDTH+1 cycles from accepted start to done; divide-by-zero finishes in 1 cycle.
// Backpressure: stall freezes IF/ID/EX from the cycle start is seen until the done cycle.
//
// Ports:
//   clk, rst_n      rising-edge clock, asynchronous active-low reset
//   start, op       request from EX (op: 00 MUL, 01 MULHU, 10 DIVU, 11 REMU), sampled in IDLE
//   opA, opB        forwarded operands, captured when the request is accepted
//   flush           kill the in-flight operation (taken branch/jump ahead of EX)
//   stall           combinational pipeline hold
//   busy, done      CALC-state decode, one-cycle result-valid pulse
//   result          selected result, held until the next completed operation
module ex_muldiv_seq #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] opA,
    input  logic [WIDTH-1:0] opB,
    input  logic             flush,
    output logic             stall,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result
);

    localparam int CNT_W = 6;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t state, state_nxt;

    logic [1:0]         op_q;
    logic [CNT_W-1:0]   cnt;
    logic [2*WIDTH-1:0] prod;     // multiply accumulator, shifted right as bits retire
    logic [WIDTH-1:0]   mcand;
    logic [WIDTH-1:0]   mplier;   // consumed LSB first
    logic [WIDTH-1:0]   rem;
    logic [WIDTH-1:0]   quo;      // starts as dividend, quotient bits shift in at the bottom
    logic [WIDTH-1:0]   dvsr;

    logic               accept;
    logic               div_by_zero;
    logic [WIDTH:0]     mul_sum;
    logic [2*WIDTH-1:0] prod_nxt;
    logic [WIDTH:0]     div_trial;
    logic               div_ok;
    logic [WIDTH-1:0]   rem_nxt;
    logic [WIDTH-1:0]   quo_nxt;
    logic [WIDTH-1:0]   calc_res;

    assign accept      = (state == S_IDLE) && start && !flush;
    assign div_by_zero = op[1] && (opB == '0);

    // One iteration of each algorithm. The final iteration's values feed the
    // result register directly so result is valid on entry to DONE.
    always_comb begin
        mul_sum   = {1'b0, prod[2*WIDTH-1:WIDTH]} + {1'b0, (mplier[0] ? mcand : {WIDTH{1'b0}})};
        prod_nxt  = {mul_sum, prod[WIDTH-1:1]};
        // rem < dvsr always holds, so bit WIDTH of the trial is a clean sign bit.
        div_trial = {rem, quo[WIDTH-1]} - {1'b0, dvsr};
        div_ok    = ~div_trial[WIDTH];
        rem_nxt   = div_ok ? div_trial[WIDTH-1:0] : {rem[WIDTH-2:0], quo[WIDTH-1]};
        quo_nxt   = {quo[WIDTH-2:0], div_ok};
        case (op_q)
            2'b00:   calc_res = prod_nxt[WIDTH-1:0];
            2'b01:   calc_res = prod_nxt[2*WIDTH-1:WIDTH];
            2'b10:   calc_res = quo_nxt;
            default: calc_res = rem_nxt;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        stall     = 1'b0;
        busy      = 1'b0;
        done      = 1'b0;
        case (state)
            S_IDLE: begin
                stall = start && !flush;
                if (accept) begin
                    state_nxt = div_by_zero ? S_DONE : S_CALC;
                end
            end
            S_CALC: begin
                stall = 1'b1;
                busy  = 1'b1;
                if (flush) begin
                    state_nxt = S_IDLE;
                end else if (cnt == LAST_CNT) begin
                    state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                done      = 1'b1;
                state_nxt = S_IDLE;
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_q   <= '0;
            cnt    <= '0;
            prod   <= '0;
            mcand  <= '0;
            mplier <= '0;
            rem    <= '0;
            quo    <= '0;
            dvsr   <= '0;
            result <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (accept) begin
                        op_q <= op;
                        cnt  <= '0;
                        if (!op[1]) begin
                            prod   <= '0;
                            mcand  <= opA;
                            mplier <= opB;
                        end else if (!div_by_zero) begin
                            rem  <= '0;
                            quo  <= opA;
                            dvsr <= opB;
                        end else begin
                            result <= op[0] ? opA : {WIDTH{1'b1}};
                        end
                    end
                end
                S_CALC: begin
                    if (!flush) begin
                        cnt <= cnt + CNT_W'(1);
                        if (!op_q[1]) begin
                            prod   <= prod_nxt;
                            mplier <= mplier >> 1;
                        end else begin
                            rem <= rem_nxt;
                            quo <= quo_nxt;
                        end
                        if (cnt == LAST_CNT) begin
                            result <= calc_res;
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule
